// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-slice helpers
// for the direct-mapped data cache controller.
package dcache_pkg;

  localparam int ADDR_WIDTH   = 10;
  localparam int INDEX_WIDTH  = 5;
  localparam int OFFSET_WIDTH = 2;
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES        = 1 << INDEX_WIDTH;
  localparam int IO_WIDTH     = INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    REFILL,
    WR_WAIT
  } state_e;

  function automatic logic [TAG_WIDTH-1:0] tag_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] index_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] block_base(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {a[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Tag/valid store: combinational lookup, one write port used on refill,
// valid bits cleared by synchronous reset.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [TAG_WIDTH-1:0]   tag,
  input  logic                   wr_en,
  output logic                   hit
);

  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q [LINES];
  logic [TAG_WIDTH-1:0] tag_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (wr_en) begin
      valid_d[index] = 1'b1;
      tag_d[index]   = tag;
    end
    if (reset) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
  end

  assign hit = valid_q[index] && (tag_q[index] == tag);

endmodule

// File: rtl/dcache_controller.sv
// Write-through, read-allocate direct-mapped D-cache sequencer:
// hit/miss decision, array strobes and main-memory handshake.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  stall,
  output logic                  hit,
  output logic                  cache_read,
  output logic                  cache_update,
  output logic                  cache_refill,
  output logic [IO_WIDTH-1:0]   cache_index_offset,
  output logic                  mm_rd,
  output logic                  mm_wr,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  input  logic                  mm_ready
);

  state_e state_q, state_d;
  logic   lookup_hit;

  dcache_tag_array u_tags (
    .clk   (clk),
    .reset (reset),
    .index (index_of(cpu_addr)),
    .tag   (tag_of(cpu_addr)),
    .wr_en (cache_refill),
    .hit   (lookup_hit)
  );

  assign cache_index_offset = cpu_addr[IO_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    hit          = lookup_hit;
    cache_read   = 1'b0;
    cache_update = 1'b0;
    cache_refill = 1'b0;
    mm_rd        = 1'b0;
    mm_wr        = 1'b0;
    mm_addr      = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          stall        = 1'b1;
          mm_wr        = 1'b1;
          mm_addr      = cpu_addr;
          cache_update = lookup_hit;
          state_d      = WR_WAIT;
        end else if (cpu_rd) begin
          if (lookup_hit) begin
            cache_read = 1'b1;
          end else begin
            stall   = 1'b1;
            mm_rd   = 1'b1;
            mm_addr = block_base(cpu_addr);
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall   = 1'b1;
        mm_rd   = 1'b1;
        mm_addr = block_base(cpu_addr);
        if (mm_ready) state_d = REFILL;
      end
      REFILL: begin
        stall        = 1'b1;
        cache_refill = 1'b1;
        state_d      = IDLE;
      end
      WR_WAIT: begin
        stall   = ~mm_ready;
        mm_wr   = 1'b1;
        mm_addr = cpu_addr;
        if (mm_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // reset masks every output except the pass-through index/offset
    if (reset) begin
      state_d      = IDLE;
      stall        = 1'b0;
      hit          = 1'b0;
      cache_read   = 1'b0;
      cache_update = 1'b0;
      cache_refill = 1'b0;
      mm_rd        = 1'b0;
      mm_wr        = 1'b0;
      mm_addr      = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed scoreboard bench for dcache_controller.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  cpu_rd = 1'b0;
  logic                  cpu_wr = 1'b0;
  logic [ADDR_WIDTH-1:0] cpu_addr = '0;
  logic                  mm_ready = 1'b0;
  logic                  stall, hit, cache_read, cache_update, cache_refill;
  logic                  mm_rd, mm_wr;
  logic [IO_WIDTH-1:0]   cache_index_offset;
  logic [ADDR_WIDTH-1:0] mm_addr;

  dcache_controller dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_rd             (cpu_rd),
    .cpu_wr             (cpu_wr),
    .cpu_addr           (cpu_addr),
    .stall              (stall),
    .hit                (hit),
    .cache_read         (cache_read),
    .cache_update       (cache_update),
    .cache_refill       (cache_refill),
    .cache_index_offset (cache_index_offset),
    .mm_rd              (mm_rd),
    .mm_wr              (mm_wr),
    .mm_addr            (mm_addr),
    .mm_ready           (mm_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    id;
    logic [6:0]            flags;
    logic [ADDR_WIDTH-1:0] addr;
    logic [IO_WIDTH-1:0]   io;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   step_n = 0;
  bit   done   = 1'b0;

  // flags = {stall,hit,read,update,refill,mm_rd,mm_wr}
  task automatic step(
    input logic                  rst,
    input logic                  rd,
    input logic                  wr,
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  rdy,
    input logic [6:0]            f,
    input logic [ADDR_WIDTH-1:0] ma
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    cpu_rd   = rd;
    cpu_wr   = wr;
    cpu_addr = a;
    mm_ready = rdy;
    e.id    = step_n;
    e.flags = f;
    e.addr  = ma;
    e.io    = a[IO_WIDTH-1:0];
    exp_q.push_back(e);
    step_n++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [6:0] got;
      e = exp_q.pop_front();
      got = {stall, hit, cache_read, cache_update,
             cache_refill, mm_rd, mm_wr};
      checks++;
      if (got !== e.flags) begin
        fails++;
        $display("FAIL step%0d flags got %b want %b",
                 e.id, got, e.flags);
      end else if ((e.flags[1] | e.flags[0]) && mm_addr !== e.addr) begin
        fails++;
        $display("FAIL step%0d mm_addr got %h want %h",
                 e.id, mm_addr, e.addr);
      end else if (cache_index_offset !== e.io) begin
        fails++;
        $display("FAIL step%0d index_offset got %h want %h",
                 e.id, cache_index_offset, e.io);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
    end
  end

  initial begin
    // reset: all outputs quiet
    step(1, 0, 0, 10'h000, 0, 7'b0000000, 10'h000);
    step(1, 1, 0, 10'h0A5, 1, 7'b0000000, 10'h000);
    // cold read 0x0A5: three mm_rd cycles, refill, then hit
    step(0, 1, 0, 10'h0A5, 0, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A5, 0, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A5, 1, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A5, 0, 7'b1000100, 10'h000);
    step(0, 1, 0, 10'h0A5, 0, 7'b0110000, 10'h000);
    // same line, zero-cycle hit
    step(0, 1, 0, 10'h0A6, 0, 7'b0110000, 10'h000);
    // store hit 0x0A5, three mm_wr cycles
    step(0, 0, 1, 10'h0A5, 0, 7'b1101001, 10'h0A5);
    step(0, 0, 1, 10'h0A5, 0, 7'b1100001, 10'h0A5);
    step(0, 0, 1, 10'h0A5, 1, 7'b0100001, 10'h0A5);
    // idle, mm_ready ignored
    step(0, 0, 0, 10'h000, 1, 7'b0000000, 10'h000);
    // store miss 0x1F0: no update
    step(0, 0, 1, 10'h1F0, 0, 7'b1000001, 10'h1F0);
    step(0, 0, 1, 10'h1F0, 1, 7'b0000001, 10'h1F0);
    // read 0x1F0 misses (no write allocate)
    step(0, 1, 0, 10'h1F0, 0, 7'b1000010, 10'h1F0);
    step(0, 1, 0, 10'h1F0, 1, 7'b1000010, 10'h1F0);
    step(0, 1, 0, 10'h1F0, 0, 7'b1000100, 10'h000);
    step(0, 1, 0, 10'h1F0, 0, 7'b0110000, 10'h000);
    // conflict on index 9
    step(0, 1, 0, 10'h0A4, 0, 7'b0110000, 10'h000);
    step(0, 1, 0, 10'h1A4, 0, 7'b1000010, 10'h1A4);
    step(0, 1, 0, 10'h1A4, 1, 7'b1000010, 10'h1A4);
    step(0, 1, 0, 10'h1A4, 0, 7'b1000100, 10'h000);
    step(0, 1, 0, 10'h1A4, 0, 7'b0110000, 10'h000);
    step(0, 1, 0, 10'h0A4, 0, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A4, 1, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A4, 0, 7'b1000100, 10'h000);
    step(0, 1, 0, 10'h0A7, 0, 7'b0110000, 10'h000);
    // rd+wr together: write wins
    step(0, 1, 1, 10'h0A4, 0, 7'b1101001, 10'h0A4);
    step(0, 1, 1, 10'h0A4, 1, 7'b0100001, 10'h0A4);
    // reset during RD_MISS with mm_ready high: no refill
    step(0, 1, 0, 10'h2A5, 0, 7'b1000010, 10'h2A4);
    step(1, 1, 0, 10'h2A5, 1, 7'b0000000, 10'h000);
    step(0, 0, 0, 10'h2A5, 0, 7'b0000000, 10'h000);
    // valid bits cleared: 0x0A5 misses; mm_ready in IDLE ignored
    step(0, 1, 0, 10'h0A5, 1, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A5, 0, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A5, 1, 7'b1000010, 10'h0A4);
    step(0, 1, 0, 10'h0A5, 0, 7'b1000100, 10'h000);
    step(0, 1, 0, 10'h0A5, 0, 7'b0110000, 10'h000);
    // reset during WR_WAIT drops mm_wr
    step(0, 0, 1, 10'h0A5, 0, 7'b1101001, 10'h0A5);
    step(1, 0, 1, 10'h0A5, 0, 7'b0000000, 10'h000);
    step(0, 0, 0, 10'h0A5, 0, 7'b0000000, 10'h000);
    step(0, 1, 0, 10'h0A5, 0, 7'b1000010, 10'h0A4);
    step(1, 0, 0, 10'h000, 0, 7'b0000000, 10'h000);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
